// File: rtl/alu_acc_pkg.sv
// Shared opcode, FSM state and error-code definitions for the accumulator ALU.
package alu_acc_pkg;

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpMul   = 4'd2,
    OpDiv   = 4'd3,
    OpAnd   = 4'd4,
    OpOr    = 4'd5,
    OpXor   = 4'd6,
    OpNot   = 4'd7,
    OpNand  = 4'd8,
    OpNor   = 4'd9,
    OpXnor  = 4'd10,
    OpShl   = 4'd11,
    OpShr   = 4'd12,
    OpNop   = 4'd13,
    OpError = 4'd14,
    OpClear = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2,
    StLock = 2'd3
  } state_e;

  localparam logic [1:0] ErrNone      = 2'd0;
  localparam logic [1:0] ErrUnderflow = 2'd1;
  localparam logic [1:0] ErrDivZero   = 2'd2;
  localparam logic [1:0] ErrOp        = 2'd3;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per cycle.
// done_o flags the final step; result_o is the value produced by that step.
module alu_iter_muldiv #(
  parameter int unsigned W = 16,
  localparam int unsigned ACC_W = 2 * W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic             done_o,
  output logic [ACC_W-1:0] result_o
);

  localparam int unsigned CntW = $clog2(W);

  logic             run_q, div_q;
  logic [CntW-1:0]  cnt_q;
  logic [ACC_W-1:0] mcand_q, prod_q, prod_nx;
  logic [W-1:0]     mplier_q, rem_q, quo_q, dvsr_q, rem_nx, quo_nx;
  logic [W:0]       rem_sh;

  // One iteration step of both datapaths; only the selected one is used.
  always_comb begin
    prod_nx = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    rem_sh  = {rem_q, quo_q[W-1]};
    if (rem_sh >= {1'b0, dvsr_q}) begin
      // Difference is below dvsr_q, so the dropped top bit is always zero.
      rem_nx = rem_sh[W-1:0] - dvsr_q;
      quo_nx = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[W-1:0];
      quo_nx = {quo_q[W-2:0], 1'b0};
    end
  end

  assign done_o   = run_q && (cnt_q == CntW'(W - 1));
  assign result_o = div_q ? {rem_nx, quo_nx} : prod_nx;

  // Load operands on start, then step once per cycle for W cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q    <= 1'b0;
      div_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      div_q    <= div_i;
      cnt_q    <= '0;
      mcand_q  <= {{W{1'b0}}, a_i};
      mplier_q <= b_i;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= a_i;
      dvsr_q   <= b_i;
    end else if (run_q) begin
      cnt_q    <= cnt_q + 1'b1;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      prod_q   <= prod_nx;
      rem_q    <= rem_nx;
      quo_q    <= quo_nx;
      if (done_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_acc_seq.sv
// Sequential accumulator ALU: single-cycle logic/arith ops, iterative MUL/DIV,
// sticky error with a LOCK state that only CLEAR leaves.
module alu_acc_seq
  import alu_acc_pkg::*;
#(
  parameter int unsigned W = 16,
  localparam int unsigned ACC_W = 2 * W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             a_sel,
  input  logic [1:0]       b_sel,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam logic [ACC_W-1:0] ShMax = ACC_W'(ACC_W);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, result_q, result_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  op_e              op_w;
  logic             accept;
  logic [W-1:0]     a_op, b_op;
  logic [ACC_W-1:0] a_ext, b_ext, alu_res;
  logic [1:0]       alu_code;
  logic             it_start, it_done;
  logic [ACC_W-1:0] it_res;

  assign op_w      = op_e'(op);
  assign in_ready  = (state_q == StIdle) || (state_q == StLock);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StBusy);
  assign result    = result_q;
  assign err       = err_q;
  assign err_code  = code_q;

  assign a_op  = a_sel ? acc_q[W-1:0] : a_in;
  assign b_op  = (b_sel == 2'd0) ? b_in : (b_sel == 2'd1) ? acc_q[W-1:0] : '0;
  assign a_ext = {{W{1'b0}}, a_op};
  assign b_ext = {{W{1'b0}}, b_op};

  // Single-cycle datapath and error detection (incl. divide-by-zero at accept).
  always_comb begin
    alu_res  = '0;
    alu_code = ErrNone;
    case (op_w)
      OpAdd:   alu_res = a_ext + b_ext;
      OpSub: begin
        if (b_op > a_op) alu_code = ErrUnderflow;
        else             alu_res  = a_ext - b_ext;
      end
      OpDiv:   if (b_op == '0) alu_code = ErrDivZero;
      OpAnd:   alu_res = {{W{1'b0}}, a_op & b_op};
      OpOr:    alu_res = {{W{1'b0}}, a_op | b_op};
      OpXor:   alu_res = {{W{1'b0}}, a_op ^ b_op};
      OpNot:   alu_res = {{W{1'b0}}, ~b_op};
      OpNand:  alu_res = {{W{1'b0}}, ~(a_op & b_op)};
      OpNor:   alu_res = {{W{1'b0}}, ~(a_op | b_op)};
      OpXnor:  alu_res = {{W{1'b0}}, ~(a_op ^ b_op)};
      OpShl:   alu_res = (a_ext >= ShMax) ? '0 : (b_ext << a_op);
      OpShr:   alu_res = (a_ext >= ShMax) ? '0 : (b_ext >> a_op);
      OpNop:   alu_res = acc_q;
      OpError: alu_code = ErrOp;
      default: alu_res = '0;
    endcase
  end

  // FSM next state plus result/accumulator/error updates.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    code_d   = code_q;
    it_start = 1'b0;
    case (state_q)
      StIdle, StLock: begin
        if (accept) begin
          state_d = StDone;
          if (op_w == OpClear) begin
            acc_d    = '0;
            result_d = '0;
            err_d    = 1'b0;
            code_d   = ErrNone;
          end else if (state_q == StLock) begin
            // Locked: answer with zero, keep the first error code.
            result_d = '0;
          end else if ((op_w == OpMul) || ((op_w == OpDiv) && (b_op != '0))) begin
            it_start = 1'b1;
            state_d  = StBusy;
          end else if (alu_code != ErrNone) begin
            result_d = '0;
            err_d    = 1'b1;
            code_d   = alu_code;
          end else begin
            result_d = alu_res;
            acc_d    = alu_res;
          end
        end
      end
      StBusy: begin
        if (it_done) begin
          result_d = it_res;
          acc_d    = it_res;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = err_q ? StLock : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      code_q   <= ErrNone;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  alu_iter_muldiv #(
    .W(W)
  ) u_iter (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .start_i  (it_start),
    .div_i    (op_w == OpDiv),
    .a_i      (a_op),
    .b_i      (b_op),
    .done_o   (it_done),
    .result_o (it_res)
  );

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq (W = 16) with an expected-result scoreboard.
module tb_alu_acc_seq;

  localparam int W     = 16;
  localparam int ACC_W = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       op = '0;
  logic             a_sel = 1'b0;
  logic [1:0]       b_sel = '0;
  logic [W-1:0]     a_in = '0;
  logic [W-1:0]     b_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] result;
  logic             err;
  logic [1:0]       err_code;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_acc = '0;
  logic        m_err = 1'b0;
  logic [1:0]  m_code = '0;
  logic [31:0] r;

  always #5 clk = ~clk;

  alu_acc_seq #(.W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference behaviour of one accepted request, updating the model state.
  function automatic exp_t predict(input logic [3:0] o, input logic [15:0] a,
                                   input logic [15:0] b);
    exp_t e;
    e = '0;
    if (o == 4'd15) begin
      m_acc = '0; m_err = 1'b0; m_code = 2'd0;
      return e;
    end
    if (m_err) begin
      e.err = 1'b1; e.code = m_code;
      return e;
    end
    case (o)
      4'd0:  e.res = {16'b0, a} + {16'b0, b};
      4'd1:  if (b > a) begin e.err = 1'b1; e.code = 2'd1; end else e.res = {16'b0, a - b};
      4'd2:  e.res = {16'b0, a} * {16'b0, b};
      4'd3:  if (b == 0) begin e.err = 1'b1; e.code = 2'd2; end else e.res = {a % b, a / b};
      4'd4:  e.res = {16'b0, a & b};
      4'd5:  e.res = {16'b0, a | b};
      4'd6:  e.res = {16'b0, a ^ b};
      4'd7:  e.res = {16'b0, ~b};
      4'd8:  e.res = {16'b0, ~(a & b)};
      4'd9:  e.res = {16'b0, ~(a | b)};
      4'd10: e.res = {16'b0, ~(a ^ b)};
      4'd11: e.res = (a >= 16'd32) ? 32'd0 : ({16'b0, b} << a);
      4'd12: e.res = (a >= 16'd32) ? 32'd0 : ({16'b0, b} >> a);
      4'd13: e.res = m_acc;
      default: begin e.err = 1'b1; e.code = 2'd3; end
    endcase
    if (e.err) begin m_err = 1'b1; m_code = e.code; end
    else m_acc = e.res;
    return e;
  endfunction

  task automatic send(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                      input logic asel, input logic [1:0] bsel);
    int n = 0;
    logic [15:0] ea, eb;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("send_ready", in_ready, 1);
    ea = asel ? m_acc[15:0] : a;
    eb = (bsel == 2'd0) ? b : (bsel == 2'd1) ? m_acc[15:0] : 16'd0;
    op = o; a_in = a; b_in = b; a_sel = asel; b_sel = bsel; in_valid = 1'b1;
    sb.push_back(predict(o, ea, eb));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, output logic [31:0] obs_res);
    int n = 0;
    exp_t e;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sb"}, sb.size() > 0, 1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, "_res"}, result, e.res);
    chk({tag, "_err"}, err, e.err);
    chk({tag, "_code"}, err_code, e.code);
    obs_res = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_result", result, 0);
    @(posedge clk); #1; reset_n = 1'b1;
    @(posedge clk); #1;

    // ADD with latency 1, then acc visible through NOP
    send(4'd0, 16'd6, 16'd3, 1'b0, 2'd0);
    chk("add_lat", out_valid, 1);
    chk("add_nine", result, 32'd9);
    recv("add", r);
    send(4'd13, 16'd0, 16'd0, 1'b0, 2'd0);
    recv("nop_acc", r);
    chk("acc_nine", r, 32'd9);

    // MUL: busy exactly W cycles, result at cycle W+1
    send(4'd2, 16'd6, 16'd3, 1'b0, 2'd0);
    for (int i = 0; i < 16; i++) begin
      chk("mul_busy", busy, 1);
      chk("mul_in_ready", in_ready, 0);
      chk("mul_no_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    chk("mul_valid_17", out_valid, 1);
    chk("mul_busy_end", busy, 0);
    recv("mul", r);
    chk("mul_18", r, 32'd18);

    // DIV, divide-by-zero into LOCK, locked op, CLEAR
    send(4'd3, 16'd7, 16'd2, 1'b0, 2'd0);
    recv("div", r);
    chk("div_quo_rem", r, 32'h0001_0003);
    send(4'd3, 16'd7, 16'd0, 1'b0, 2'd0);
    chk("dz_no_busy", busy, 0);
    recv("divz", r);
    chk("dz_err", err, 1);
    chk("dz_code", err_code, 2'd2);
    send(4'd0, 16'd1, 16'd1, 1'b0, 2'd0);
    recv("lock_add", r);
    chk("lock_res0", r, 32'd0);
    send(4'd15, 16'd0, 16'd0, 1'b0, 2'd0);
    recv("clear", r);
    chk("clear_err", err, 0);
    send(4'd13, 16'd0, 16'd0, 1'b0, 2'd0);
    recv("nop_clr", r);
    chk("acc_cleared", r, 32'd0);

    // SUB underflow, shifts, logic ops, operand selects
    send(4'd1, 16'd3, 16'd6, 1'b0, 2'd0);
    recv("sub_uf", r);
    chk("sub_uf_code", err_code, 2'd1);
    send(4'd15, 16'd0, 16'd0, 1'b0, 2'd0);
    recv("clear2", r);
    send(4'd11, 16'd1, 16'd5, 1'b0, 2'd0);
    recv("shl1", r);
    chk("shl_ten", r, 32'd10);
    send(4'd11, 16'd40, 16'd5, 1'b0, 2'd0);
    recv("shl40", r);
    chk("shl_zero", r, 32'd0);
    send(4'd11, 16'd31, 16'd3, 1'b0, 2'd0);
    recv("shl31", r);
    send(4'd12, 16'd2, 16'hF0F0, 1'b0, 2'd0);
    recv("shr", r);
    send(4'd1, 16'd9, 16'd9, 1'b0, 2'd0);
    recv("sub_eq", r);
    for (int o = 4; o <= 10; o++) begin
      send(4'(o), 16'hA5C3, 16'h0FF0, 1'b0, 2'd0);
      recv("logic", r);
    end
    send(4'd0, 16'h1234, 16'h0001, 1'b0, 2'd0);
    recv("add_seed", r);
    send(4'd0, 16'd0, 16'd0, 1'b1, 2'd1);
    recv("add_accacc", r);
    send(4'd0, 16'd0, 16'd7, 1'b1, 2'd2);
    recv("add_bzero", r);
    send(4'd0, 16'hFFFF, 16'hFFFF, 1'b0, 2'd0);
    recv("add_carry", r);
    chk("add_carry_bit", r, 32'h0001_FFFE);
    send(4'd2, 16'hFFFF, 16'hFFFF, 1'b0, 2'd0);
    recv("mul_max", r);
    send(4'd3, 16'hFFFF, 16'd7, 1'b0, 2'd0);
    recv("div_max", r);
    send(4'd14, 16'd0, 16'd0, 1'b0, 2'd0);
    recv("op_err", r);
    send(4'd15, 16'd0, 16'd0, 1'b0, 2'd0);
    recv("clear3", r);

    // Back-pressure: output held while out_ready is low
    send(4'd0, 16'd20, 16'd22, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 32'd42);
      chk("hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    recv("hold", r);
    chk("after_hs_ready", in_ready, 1);
    send(4'd0, 16'd1, 16'd2, 1'b0, 2'd0);
    chk("next_accept", out_valid, 1);
    recv("next", r);

    // Reset in the middle of a MUL
    send(4'd2, 16'd6, 16'd3, 1'b0, 2'd0);
    repeat (4) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_result", result, 0);
    sb.delete();
    m_acc = '0; m_err = 1'b0; m_code = 2'd0;
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("abort_no_out", out_valid, 0);
    end
    send(4'd13, 16'd0, 16'd0, 1'b0, 2'd0);
    recv("nop_rst", r);
    chk("acc_rst_zero", r, 32'd0);
    send(4'd0, 16'd1, 16'd1, 1'b0, 2'd0);
    recv("post_rst", r);
    chk("post_rst_two", r, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_acc_seq.md
ALU_ACC_SEQ -- requirements
Module: alu_acc_seq

Interface
REQ-001 Parameter W, default 16: operand width, W >= 4; ACC_W = 2*W, derived, result and accumulator width.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  request present; in_ready  out  1  block can accept.
REQ-005 op  in  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 NAND, 9 NOR, 10 XNOR, 11 SHL, 12 SHR, 13 NOP, 14 ERROR, 15 CLEAR.
REQ-006 a_sel  in  1  0: a_in, 1: acc[W-1:0]; b_sel  in  2  0: b_in, 1: acc[W-1:0], 2/3: zero.
REQ-007 a_in, b_in  in  W  operands.
REQ-008 out_valid  out  1  result present; out_ready  in  1  consumer accepts.
REQ-009 result  out  ACC_W; err  out  1; err_code  out  2 (0 none, 1 sub underflow, 2 divide by zero, 3 op ERROR); busy  out  1.

Function
REQ-010 Request accepted on rising edge with in_valid && in_ready; op, selected a and b captured at that edge; in_ready = 1 only in IDLE and LOCK.
REQ-011 States IDLE, BUSY, DONE, LOCK; IDLE->DONE for single-cycle ops, IDLE->BUSY for MUL/DIV, BUSY->DONE after W iterations, DONE->IDLE (or LOCK if err) on out_valid && out_ready.
REQ-012 Single-cycle ops: out_valid asserted the cycle after acceptance (latency 1).
REQ-013 MUL/DIV: iterative, one bit per cycle; busy = 1 exactly W cycles; out_valid asserted W+1 cycles after acceptance.
REQ-014 ADD: result = zero-extended a + b including carry at bit W.
REQ-015 SUB: b > a -> err_code 1, result 0; else a - b zero-extended.
REQ-016 MUL: unsigned a*b, full ACC_W.
REQ-017 DIV: result[W-1:0] = a/b quotient, result[ACC_W-1:W] = remainder; b = 0 -> err_code 2, result 0, detected at acceptance, no BUSY.
REQ-018 AND/OR/XOR/NAND/NOR/XNOR/NOT(of b): W-bit result, upper W bits zero.
REQ-019 SHL/SHR: b zero-extended to ACC_W shifted by a; shift amount >= ACC_W -> 0.
REQ-020 NOP: result = acc, acc unchanged; ERROR op: err_code 3, result 0.
REQ-021 CLEAR: acc = 0, err = 0, err_code = 0, result 0, out_valid next cycle, next state IDLE; accepted in IDLE and LOCK.
REQ-022 acc loaded with result on entry to DONE when err = 0; unchanged on error.
REQ-023 result, err, err_code, out_valid stable in DONE until out_ready; out_ready ignored when out_valid = 0.
REQ-024 LOCK: any op other than CLEAR accepted, answered after 1 cycle with err = 1, previous err_code, result 0, acc unchanged.
REQ-025 err stays 1 from first error until CLEAR or reset.

Reset
REQ-026 reset_n low immediately: state IDLE, acc 0, result 0, out_valid 0, err 0, err_code 0, busy 0; in_ready = 1 (IDLE).
REQ-027 reset_n low during BUSY or DONE aborts operation; no result delivered.

Structure
REQ-028 Package alu_acc_pkg holds opcode enum, state enum, error-code constants.
REQ-029 Sub-module alu_iter_muldiv: shift-add multiplier and restoring divider, start/done handshake, parameter W.

Verification (W = 16)
REQ-030 a=6, b=3, op 0 -> result 9 one cycle after accept, acc = 9, err 0.
REQ-031 a=6, b=3, op 2 -> busy 16 cycles, in_ready 0, result 18 at cycle 17.
REQ-032 a=7, b=2, op 3 -> result 0x00010003; then b=0, op 3 -> err 1, err_code 2, acc unchanged; op 0 -> err 1, result 0; op 15 -> err 0, acc 0.
REQ-033 a=3, b=6, op 1 -> err_code 1; a=1, b=5, op 11 -> 10; a=40, op 11 -> 0.
REQ-034 out_ready low 5 cycles after ADD -> result/out_valid stable, in_ready 0; next request accepted one cycle after handshake.
REQ-035 reset_n low at MUL cycle 5 -> out_valid 0, busy 0, acc 0 same cycle; after release op 0 with a=1, b=1 -> 2.
